// File: rtl/test_sequencer.sv
// Run controller for the arithmetic bench: resets the monitor, warms up, streams
// LFSR operand pairs to DUT/monitor, drains, counts mismatch events and reports pass/fail.
module test_sequencer #(
    parameter int          WIDTH         = 32,
    parameter int          RST_CYCLES    = 4,
    parameter int          WARMUP_CYCLES = 6,
    parameter int          DRAIN_CYCLES  = 8,
    parameter logic [31:0] SEED_A        = 32'h1,
    parameter logic [31:0] SEED_B        = 32'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [15:0]      i_num_vectors,
    input  logic [15:0]      i_max_errors,
    input  logic             i_event,
    output logic [WIDTH-1:0] o_dut_ia,
    output logic [WIDTH-1:0] o_dut_ib,
    output logic             o_mon_reset,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [15:0]      o_err_count,
    output logic [15:0]      o_vec_count
);

    typedef enum logic [2:0] {S_IDLE, S_MRST, S_WARMUP, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           r_state;
    logic [15:0]      r_cnt;
    logic [15:0]      r_num;
    logic [15:0]      r_max;
    logic [WIDTH-1:0] r_lfsr_a;
    logic [WIDTH-1:0] r_lfsr_b;
    logic [WIDTH-1:0] r_ia;
    logic [WIDTH-1:0] r_ib;
    logic             r_mon_reset;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [15:0]      r_err_count;
    logic [15:0]      r_vec_count;

    logic             w_ev;
    logic [15:0]      w_err_next;
    logic             w_early;
    logic             w_abort;
    logic             w_last_vec;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return s[0] ? ((s >> 1) ^ WIDTH'(32'h80200003)) : (s >> 1);
    endfunction

    assign w_ev       = i_event && (r_state == S_RUN || r_state == S_DRAIN);
    assign w_err_next = (w_ev && r_err_count != 16'hFFFF) ? r_err_count + 16'd1 : r_err_count;
    assign w_early    = w_ev && (r_max != 16'd0) && (w_err_next >= r_max);
    assign w_abort    = i_abort && (r_state == S_MRST || r_state == S_WARMUP ||
                                    r_state == S_RUN  || r_state == S_DRAIN);
    assign w_last_vec = (r_vec_count + 16'd1) == r_num;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_num       <= '0;
            r_max       <= '0;
            r_lfsr_a    <= SEED_A;
            r_lfsr_b    <= SEED_B;
            r_ia        <= '0;
            r_ib        <= '0;
            r_mon_reset <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_vec_count <= '0;
        end else begin
            if (w_ev)
                r_err_count <= w_err_next;
            // Every RUN cycle issues a vector, including one cut short by abort/early stop
            if (r_state == S_RUN)
                r_vec_count <= r_vec_count + 16'd1;

            if (w_abort || w_early) begin
                r_state     <= S_DONE;
                r_done      <= 1'b1;
                r_pass      <= 1'b0;
                r_ia        <= '0;
                r_ib        <= '0;
                r_mon_reset <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_num       <= i_num_vectors;
                            r_max       <= i_max_errors;
                            r_err_count <= '0;
                            r_vec_count <= '0;
                            r_pass      <= 1'b0;
                            r_lfsr_a    <= SEED_A;
                            r_lfsr_b    <= SEED_B;
                            r_cnt       <= '0;
                            r_mon_reset <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= S_MRST;
                        end
                    end
                    S_MRST: begin
                        r_cnt <= r_cnt + 16'd1;
                        if (r_cnt == 16'(RST_CYCLES - 1)) begin
                            r_cnt       <= '0;
                            r_mon_reset <= 1'b0;
                            r_state     <= S_WARMUP;
                        end
                    end
                    S_WARMUP: begin
                        r_cnt <= r_cnt + 16'd1;
                        if (r_cnt == 16'(WARMUP_CYCLES - 1)) begin
                            r_cnt <= '0;
                            if (r_num == 16'd0) begin
                                r_state <= S_DRAIN;
                            end else begin
                                r_ia     <= r_lfsr_a;
                                r_ib     <= r_lfsr_b;
                                r_lfsr_a <= lfsr_next(r_lfsr_a);
                                r_lfsr_b <= lfsr_next(r_lfsr_b);
                                r_state  <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        if (w_last_vec) begin
                            r_ia    <= '0;
                            r_ib    <= '0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_ia     <= r_lfsr_a;
                            r_ib     <= r_lfsr_b;
                            r_lfsr_a <= lfsr_next(r_lfsr_a);
                            r_lfsr_b <= lfsr_next(r_lfsr_b);
                        end
                    end
                    S_DRAIN: begin
                        r_cnt <= r_cnt + 16'd1;
                        if (r_cnt == 16'(DRAIN_CYCLES - 1)) begin
                            r_cnt   <= '0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == 16'd0);
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_dut_ia    = r_ia;
    assign o_dut_ib    = r_ib;
    assign o_mon_reset = r_mon_reset;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_err_count = r_err_count;
    assign o_vec_count = r_vec_count;

endmodule

// File: tb/tb_test_sequencer.sv
// Directed bench for test_sequencer; expected values hand-computed from the operating rules.
module tb_test_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic        i_abort;
    logic [15:0] i_num_vectors;
    logic [15:0] i_max_errors;
    logic        i_event;
    logic [31:0] o_dut_ia;
    logic [31:0] o_dut_ib;
    logic        o_mon_reset;
    logic        o_busy;
    logic        o_done;
    logic        o_pass;
    logic [15:0] o_err_count;
    logic [15:0] o_vec_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    test_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_num_vectors(i_num_vectors),
        .i_max_errors (i_max_errors),
        .i_event      (i_event),
        .o_dut_ia     (o_dut_ia),
        .o_dut_ib     (o_dut_ib),
        .o_mon_reset  (o_mon_reset),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_pass       (o_pass),
        .o_err_count  (o_err_count),
        .o_vec_count  (o_vec_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Pulses start; afterwards the bench sits at start+1 and t0 marks the start cycle.
    task automatic start_run(input logic [15:0] n, input logic [15:0] m, output int t0);
        i_num_vectors = n;
        i_max_errors  = m;
        i_start       = 1'b1;
        t0            = cyc;
        tick();
        i_start       = 1'b0;
    endtask

    task automatic wait_done(input int t0, output int lat);
        int k = 0;
        while (!o_done && k < 300) begin
            tick();
            k++;
        end
        lat = o_done ? (cyc - t0) : -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({o_busy, o_done, o_pass, o_mon_reset, o_err_count, o_vec_count, o_dut_ia, o_dut_ib} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b pass=%b mrst=%b err=%0d vec=%0d ia=%h ib=%h, want all 0",
                     o_busy, o_done, o_pass, o_mon_reset, o_err_count, o_vec_count, o_dut_ia, o_dut_ib);
        end
        reset = 1'b0;
        tick();
        n_tests++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy=%b want 0", o_busy); end
    endtask

    task automatic test_basic();
        int t0, k, lat;
        start_run(16'd4, 16'd0, t0);
        n_tests++;
        if (o_busy !== 1'b1 || o_mon_reset !== 1'b1) begin
            n_fail++; $display("FAIL start_response: busy=%b mrst=%b want 1/1", o_busy, o_mon_reset);
        end
        k = 0;
        while (o_mon_reset && k < 20) begin k++; tick(); end
        n_tests++;
        if (k !== 4) begin n_fail++; $display("FAIL mon_reset_len: got %0d want 4", k); end
        n_tests++;
        if (o_dut_ia !== 32'h0 || o_dut_ib !== 32'h0) begin
            n_fail++; $display("FAIL warmup_operands: ia=%h ib=%h want 0/0", o_dut_ia, o_dut_ib);
        end
        repeat (6) tick();
        n_tests++;
        if (o_dut_ia !== 32'h00000001 || o_dut_ib !== 32'h0000ACE1) begin
            n_fail++; $display("FAIL vec0: ia=%h ib=%h want 00000001/0000ace1", o_dut_ia, o_dut_ib);
        end
        tick();
        // (s>>1)^80200003 for odd s
        n_tests++;
        if (o_dut_ia !== 32'h80200003 || o_dut_ib !== 32'h80205673) begin
            n_fail++; $display("FAIL vec1: ia=%h ib=%h want 80200003/80205673", o_dut_ia, o_dut_ib);
        end
        tick();
        n_tests++;
        if (o_dut_ia !== 32'hC0300002 || o_dut_ib !== 32'hC0302B3A) begin
            n_fail++; $display("FAIL vec2: ia=%h ib=%h want c0300002/c0302b3a", o_dut_ia, o_dut_ib);
        end
        wait_done(t0, lat);
        n_tests++;
        if (lat !== 23) begin n_fail++; $display("FAIL basic_latency: got %0d want 23", lat); end
        n_tests++;
        if (o_pass !== 1'b1 || o_vec_count !== 16'd4 || o_err_count !== 16'd0) begin
            n_fail++; $display("FAIL basic_result: pass=%b vec=%0d err=%0d want 1/4/0", o_pass, o_vec_count, o_err_count);
        end
        tick();
        n_tests++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_dut_ia !== 32'h0) begin
            n_fail++; $display("FAIL after_done: busy=%b done=%b ia=%h want 0/0/0", o_busy, o_done, o_dut_ia);
        end
        repeat (3) tick();
        n_tests++;
        if (o_pass !== 1'b1 || o_vec_count !== 16'd4) begin
            n_fail++; $display("FAIL idle_hold: pass=%b vec=%0d want 1/4", o_pass, o_vec_count);
        end
    endtask

    task automatic test_events();
        int t0;
        start_run(16'd10, 16'd0, t0);
        // Warmup t+5..10, run t+11..20, drain t+21..28, done t+29
        for (int k = 1; k < 29; k++) begin
            i_event = (k == 6 || k == 8 || k == 12 || k == 14 || k == 16 || k == 24);
            tick();
            if (k == 10) begin
                n_tests++;
                if (o_err_count !== 16'd0) begin n_fail++; $display("FAIL warmup_events: err=%0d want 0", o_err_count); end
            end
            if (k == 12) begin
                n_tests++;
                if (o_err_count !== 16'd1) begin n_fail++; $display("FAIL event_latency: err=%0d want 1", o_err_count); end
            end
        end
        i_event = 1'b0;
        n_tests++;
        if (o_done !== 1'b1 || o_err_count !== 16'd4 || o_pass !== 1'b0 || o_vec_count !== 16'd10) begin
            n_fail++; $display("FAIL events_result: done=%b err=%0d pass=%b vec=%0d want 1/4/0/10",
                               o_done, o_err_count, o_pass, o_vec_count);
        end
        repeat (2) tick();
    endtask

    task automatic test_early_stop();
        int t0;
        start_run(16'd100, 16'd2, t0);
        // Events on run vectors 5 and 7 (0-based) at t+16 and t+18
        for (int k = 1; k < 19; k++) begin
            i_event = (k == 16 || k == 18);
            tick();
        end
        i_event = 1'b0;
        n_tests++;
        if (o_done !== 1'b1 || o_vec_count !== 16'd8 || o_err_count !== 16'd2 || o_pass !== 1'b0) begin
            n_fail++; $display("FAIL early_stop: done=%b vec=%0d err=%0d pass=%b want 1/8/2/0",
                               o_done, o_vec_count, o_err_count, o_pass);
        end
        repeat (2) tick();
    endtask

    task automatic test_abort();
        int t0;
        start_run(16'd50, 16'd0, t0);
        for (int k = 1; k < 14; k++) begin
            i_start = (k == 12);
            i_abort = (k == 13);
            tick();
        end
        i_start = 1'b0;
        i_abort = 1'b0;
        n_tests++;
        if (o_done !== 1'b1 || o_pass !== 1'b0 || o_vec_count !== 16'd3) begin
            n_fail++; $display("FAIL abort_result: done=%b pass=%b vec=%0d want 1/0/3", o_done, o_pass, o_vec_count);
        end
        repeat (6) tick();
        n_tests++;
        if (o_busy !== 1'b0 || o_vec_count !== 16'd3 || o_mon_reset !== 1'b0) begin
            n_fail++; $display("FAIL start_ignored: busy=%b vec=%0d mrst=%b want 0/3/0", o_busy, o_vec_count, o_mon_reset);
        end
    endtask

    task automatic test_zero();
        int t0, k, nz;
        i_abort = 1'b1;
        start_run(16'd0, 16'd0, t0);
        i_abort = 1'b0;
        n_tests++;
        if (o_busy !== 1'b1) begin n_fail++; $display("FAIL start_over_abort: busy=%b want 1", o_busy); end
        k  = 1;
        nz = 0;
        while (!o_done && k < 100) begin
            if (o_dut_ia !== 32'h0 || o_dut_ib !== 32'h0) nz++;
            tick();
            k++;
        end
        n_tests++;
        if (k !== 19 || nz !== 0) begin n_fail++; $display("FAIL zero_latency: got %0d nonzero=%0d want 19/0", k, nz); end
        n_tests++;
        if (o_vec_count !== 16'd0 || o_pass !== 1'b1) begin
            n_fail++; $display("FAIL zero_result: vec=%0d pass=%b want 0/1", o_vec_count, o_pass);
        end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_run();
        int t0, dones, lat;
        start_run(16'd20, 16'd0, t0);
        repeat (12) tick();
        n_tests++;
        if (o_dut_ia !== 32'hC0300002) begin n_fail++; $display("FAIL mid_run_vec: ia=%h want c0300002", o_dut_ia); end
        reset = 1'b1;
        tick();
        n_tests++;
        if ({o_busy, o_done, o_pass, o_mon_reset, o_err_count, o_vec_count, o_dut_ia, o_dut_ib} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: busy=%b done=%b pass=%b mrst=%b err=%0d vec=%0d ia=%h ib=%h, want all 0",
                     o_busy, o_done, o_pass, o_mon_reset, o_err_count, o_vec_count, o_dut_ia, o_dut_ib);
        end
        reset = 1'b0;
        dones = 0;
        repeat (30) begin
            tick();
            if (o_done) dones++;
        end
        n_tests++;
        if (dones !== 0) begin n_fail++; $display("FAIL no_done_after_reset: got %0d pulses want 0", dones); end
        start_run(16'd2, 16'd0, t0);
        repeat (10) tick();
        n_tests++;
        if (o_dut_ia !== 32'h00000001 || o_dut_ib !== 32'h0000ACE1) begin
            n_fail++; $display("FAIL rerun_vec0: ia=%h ib=%h want 00000001/0000ace1", o_dut_ia, o_dut_ib);
        end
        tick();
        n_tests++;
        if (o_dut_ia !== 32'h80200003 || o_dut_ib !== 32'h80205673) begin
            n_fail++; $display("FAIL rerun_vec1: ia=%h ib=%h want 80200003/80205673", o_dut_ia, o_dut_ib);
        end
        wait_done(t0, lat);
        n_tests++;
        if (lat !== 21 || o_pass !== 1'b1 || o_vec_count !== 16'd2) begin
            n_fail++; $display("FAIL rerun_done: lat=%0d pass=%b vec=%0d want 21/1/2", lat, o_pass, o_vec_count);
        end
        repeat (2) tick();
    endtask

    initial begin
        reset         = 1'b1;
        i_start       = 1'b0;
        i_abort       = 1'b0;
        i_event       = 1'b0;
        i_num_vectors = '0;
        i_max_errors  = '0;
        test_reset();
        test_basic();
        test_events();
        test_early_stop();
        test_abort();
        test_zero();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
